// File: rtl/gate3_stim_chk.sv
// ============================================================================
// Module      : gate3_stim_chk
// Description : Stimulus/response checker for a 3-input NAND cell. Sweeps all
//               eight input vectors PASSES times, samples y after a settle
//               window and reports pass/fail, error count and first failure.
//               Optional macro GATE3_CHK_STOP_ON_FAIL_EN ends a run on the
//               first mismatch.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate3_stim_chk #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] fail_vec,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] C_LAST_PASS   = 5'(PASSES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [4:0] pass_idx_q, pass_idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] err_count_q, err_count_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic       fail_valid_q, fail_valid_d;

    logic       w_mismatch;
    logic       w_last_vec;
    logic       w_end_run;
    logic [7:0] w_err_inc;

    assign w_mismatch = (y != ~(vec_q[2] & vec_q[1] & vec_q[0]));
    assign w_last_vec = (vec_q == 3'd7) && (pass_idx_q == C_LAST_PASS);
    assign w_err_inc  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
`ifdef GATE3_CHK_STOP_ON_FAIL_EN
    assign w_end_run  = w_last_vec | w_mismatch;
`else
    assign w_end_run  = w_last_vec;
`endif

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        pass_idx_d   = pass_idx_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d        = 3'd0;
                    pass_idx_d   = 5'd0;
                    err_count_d  = 8'd0;
                    pass_d       = 1'b0;
                    fail_vec_d   = 3'd0;
                    fail_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = C_SETTLE_LOAD;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (w_mismatch) begin
                    err_count_d = w_err_inc;
                    if (!fail_valid_q) begin
                        fail_vec_d   = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (w_end_run) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // err_count_q alone misses a mismatch on this final sample
                    pass_d  = !w_mismatch && (err_count_q == 8'd0);
                end else begin
                    vec_d = vec_q + 3'd1;
                    if (vec_q == 3'd7) begin
                        pass_idx_d = pass_idx_q + 5'd1;
                    end
                    cnt_d   = C_SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= 3'd0;
            pass_idx_q   <= 5'd0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 8'd0;
            fail_vec_q   <= 3'd0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            pass_idx_q   <= pass_idx_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    assign a          = vec_q[2];
    assign b          = vec_q[1];
    assign c          = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_gate3_stim_chk.sv
// ============================================================================
// Module      : tb_gate3_stim_chk
// Description : Self-checking bench for gate3_stim_chk: time-based reference
//               model compared every cycle, plus literal end-of-run results.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate3_stim_chk;

    localparam int S = 2;
    localparam int P = 2;
    localparam int N = 8 * P * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a, b, c, y;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count;
    logic [2:0] fail_vec;

    int  mode = 0;
    bit  flip = 1'b0;
    int  n_pass = 0;
    int  n_total = 0;

    // 0 ideal NAND, 1 stuck-at-1, 2 AND, 3 stuck-at-0, 4 NAND with random flips
    assign y = (mode == 0) ? ~(a & b & c) :
               (mode == 1) ? 1'b1 :
               (mode == 2) ? (a & b & c) :
               (mode == 3) ? 1'b0 : (~(a & b & c) ^ flip);

    gate3_stim_chk #(.SETTLE_CYCLES(S), .PASSES(P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .c(c), .y(y),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    always #5 clk = ~clk;

    // Reference model: a run is described by the number of edges since E0.
    int         edge_no = 0;
    int         m_phase = 0;
    int         m_t = 0;
    int         m_e0 = 0;
    int         m_err = 0;
    logic [2:0] m_vec = 3'd0;
    logic [2:0] m_fv = 3'd0;
    logic [2:0] m_sv;
    bit         m_fvalid = 0, m_busy = 0, m_done = 0, m_pass = 0, m_mis, m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_t = 0; m_err = 0; m_vec = 3'd0; m_fv = 3'd0;
            m_fvalid = 0; m_busy = 0; m_done = 0; m_pass = 0;
        end else begin
            edge_no = edge_no + 1;
            m_done  = 0;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1; m_t = 0; m_e0 = edge_no; m_err = 0; m_vec = 3'd0;
                    m_fv = 3'd0; m_fvalid = 0; m_pass = 0; m_busy = 1;
                end
            end else if (m_phase == 1) begin
                m_t = m_t + 1;
                if (m_t % (S + 1) == 0) begin
                    m_sv  = 3'((m_t / (S + 1) - 1) % 8);
                    m_mis = (y !== ~(m_sv[2] & m_sv[1] & m_sv[0]));
                    if (m_mis) begin
                        if (m_err < 255) m_err = m_err + 1;
                        if (!m_fvalid) begin m_fv = m_sv; m_fvalid = 1; end
                    end
                    m_last = (m_t == N);
`ifdef GATE3_CHK_STOP_ON_FAIL_EN
                    m_last = m_last || m_mis;
`endif
                    if (m_last) begin
                        m_phase = 2; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                    end
                end
                if (m_phase == 1) m_vec = 3'((m_t / (S + 1)) % 8);
            end else begin
                m_phase = 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("abc",        int'({a, b, c}), int'(m_vec));
            chk("busy",       int'(busy),       int'(m_busy));
            chk("done",       int'(done),       int'(m_done));
            chk("pass",       int'(pass),       int'(m_pass));
            chk("err_count",  int'(err_count),  m_err);
            chk("fail_vec",   int'(fail_vec),   int'(m_fv));
            chk("fail_valid", int'(fail_valid), int'(m_fvalid));
        end
        flip = (mode == 4) && ($urandom_range(0, 7) == 0);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_abc"},        int'({a, b, c}),  0);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_done"},       int'(done),       0);
        chk({tag, "_pass"},       int'(pass),       0);
        chk({tag, "_err_count"},  int'(err_count),  0);
        chk({tag, "_fail_vec"},   int'(fail_vec),   0);
        chk({tag, "_fail_valid"}, int'(fail_valid), 0);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_vec(input logic [2:0] v);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (busy && {a, b, c} == v) seen = 1;
        end
        if (!seen) chk("vec_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Directed run with hand-computed end-of-run results and done latency.
    task automatic run_lit(input string nm, input int md, input bit repulse,
                           input int e_err, input int e_fv, input int e_fvalid,
                           input int e_pass, input int e_lat, input int e_abc);
        mode = md;
        pulse_start();
        if (repulse) begin
            wait_vec(3'd3);
            start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        wait_done();
        chk({nm, "_err"},        int'(err_count),  e_err);
        chk({nm, "_fail_vec"},   int'(fail_vec),   e_fv);
        chk({nm, "_fail_valid"}, int'(fail_valid), e_fvalid);
        chk({nm, "_pass"},       int'(pass),       e_pass);
        chk({nm, "_latency"},    edge_no - m_e0,   e_lat);
        chk({nm, "_abc"},        int'({a, b, c}),  e_abc);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef GATE3_CHK_STOP_ON_FAIL_EN
        run_lit("ideal",   0, 0, 0, 0, 0, 1, N, 7);
        run_lit("stuck1",  1, 0, 1, 7, 1, 0, 8 * (S + 1), 7);
        run_lit("and",     2, 0, 1, 0, 1, 0, S + 1, 0);
        run_lit("stuck0",  3, 0, 1, 0, 1, 0, S + 1, 0);
        run_lit("repulse", 0, 1, 0, 0, 0, 1, N, 7);
`else
        run_lit("ideal",   0, 0, 0, 0, 0, 1, 48, 7);
        run_lit("stuck1",  1, 0, 2, 7, 1, 0, 48, 7);
        run_lit("and",     2, 0, 16, 0, 1, 0, 48, 7);
        run_lit("stuck0",  3, 0, 14, 0, 1, 0, 48, 7);
        run_lit("repulse", 0, 1, 0, 0, 0, 1, 48, 7);
`endif

        mode = 4;
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            wait_done();
        end

        // Start held high: runs re-launch back-to-back.
        @(negedge clk); start = 1'b1;
        wait_done();
        wait_done();
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-run aborts and the run does not resume.
        mode = 0;
        pulse_start();
        wait_vec(3'd5);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        run_lit("after_reset", 0, 0, 0, 0, 0, 1, N, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/gate3_stim_chk.md
# gate3_stim_chk

Self-checking stimulus/response stage for the three-input NAND cell. It sits directly upstream and downstream of the cell under test: it drives the cell's `a`/`b`/`c` inputs through all eight input combinations, samples the cell's `y` output, and compares it against the expected NAND value. It reports pass/fail, an error count and the first failing vector. It is the silicon/gate-level bring-up harness for the combinational cell library.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles a vector is held before `y` is sampled. Legal range 1..15.
- `PASSES`, default 1: number of full 8-vector sweeps per run. Legal range 1..31.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `a`, `b`, `c`  out  1 each  registered drive to the cell; `{a,b,c} = vec[2:0]`.
- `y`  in  1  cell output under test.
- `busy`  out  1  high from the start-acceptance edge until the edge that enters FINISH.
- `done`  out  1  one-cycle pulse when a run ends.
- `pass`  out  1  high if the last run had zero mismatches; held until the next start.
- `err_count`  out  8  mismatch count of the current/last run; saturates at 255.
- `fail_vec`  out  3  vector `{a,b,c}` of the first mismatch.
- `fail_valid`  out  1  `fail_vec` is meaningful.

## Operation
- Clock and reset: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- **IDLE:** when `start=1`:
  - clear `vec`, pass index, `err_count`, `pass`, `fail_valid`, `fail_vec`;
  - set `busy`, load the settle counter with `SETTLE_CYCLES-1`;
  - go to SETTLE.
- **SETTLE:** hold `vec`; decrement the counter. When the counter is 0, go to SAMPLE.
- **SAMPLE:** at the edge ending this cycle:
  - Compare: expected = `~(vec[2]&vec[1]&vec[0])`; a mismatch occurs when `y != expected`.
  - On a mismatch: increment `err_count` (saturating). If `fail_valid=0`, load `fail_vec=vec` and set `fail_valid`.
  - If `vec==7` and pass index `==PASSES-1`: go to FINISH, clear `busy`, set `pass = (no mismatch in the run, including this sample)`.
  - Otherwise: `vec <= vec+1` (wraps 7→0, incrementing the pass index), reload the settle counter, go to SETTLE.
- **FINISH:** `done=1` for exactly one cycle, then IDLE.
- Boundary conditions:
  - `start` while not IDLE is ignored; no queuing.
  - `start` held high through FINISH is not accepted until IDLE; holding it permanently re-runs back-to-back.
  - `rst_n` low mid-run aborts immediately, with all outputs at reset values. A run never resumes after reset.
  - `a`/`b`/`c` keep their last driven value in IDLE/FINISH; they are cleared to 0 only by reset or start.
- Reset values: `a=b=c=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_vec=0`, `fail_valid=0`, state IDLE.

## Timing
- Let E0 be the edge accepting `start`. `a`/`b`/`c` show vector 0 after E0.
- Each vector occupies S+1 cycles (S = `SETTLE_CYCLES`): S in SETTLE plus 1 in SAMPLE.
- `y` must be stable within S cycles of the vector change; this is the combinational cell's settle budget.
- The last sample occurs at edge E0 + 8·P·(S+1). FINISH is entered at that edge, and `done` is high in the following cycle.
- `pass`, `err_count` and `fail_*` are final and valid when `done=1`.
- `err_count`/`fail_*` update at each SAMPLE edge and are readable mid-run.
- Back-to-back runs: minimum 2 cycles (FINISH, IDLE) between the last sample edge and the next acceptance edge.

## Configuration
- Macro: `GATE3_CHK_STOP_ON_FAIL_EN`.
- Defined: the first mismatch ends the run.
  - That SAMPLE edge goes to FINISH with `pass=0`, `err_count=1`, `fail_valid=1`.
  - The remaining vectors are not driven.
- Undefined: every run completes all 8·P vectors regardless of mismatches.

## Test plan
- Ideal NAND model on `y`, S=2, P=1, pulse `start`:
  - vectors 000..111 each held 3 cycles;
  - `done` one cycle after edge E0+24;
  - `pass=1`, `err_count=0`, `fail_valid=0`.
- `y` stuck-at-1, S=2, P=2 → `err_count=2`, `fail_vec=3'b111`, `pass=0`, `done` after edge E0+48.
- `y` driven as AND (inverted NAND), S=1, P=1 → `err_count=8`, `fail_vec=3'b000`, `done` after edge E0+16.
- `start` re-pulsed at vector 3 mid-run → ignored; run completes at the original timing. Then assert `rst_n=0` at vector 5 of a second run → all outputs at reset values on the next clock-free check, state IDLE.
- With `GATE3_CHK_STOP_ON_FAIL_EN`, `y` stuck-at-0, S=2 → FINISH at edge E0+3, `err_count=1`, `fail_vec=3'b000`, `pass=0`, `a`/`b`/`c` remain 000.
